// File: rtl/serial_adder_arbiter_if.sv
// rtl/serial_adder_arbiter_if.sv - requester/result bundle for the shared bit-serial adder
interface serial_adder_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             cin0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             cin1;
    logic             busy;
    logic             grant;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output req0, a0, b0, cin0,
        output req1, a1, b1, cin1,
        input  busy, grant, done, sum, cout
    );

    modport slave (
        input  req0, a0, b0, cin0,
        input  req1, a1, b1, cin1,
        output busy, grant, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_arbiter.sv
// rtl/serial_adder_arbiter.sv - round-robin shared bit-serial adder built on a NOR full-adder cell
module full_adder_nor (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);
    logic n_ab, n_a, n_b, x_ab, n_xc, n_x, n_c;

    // Four NORs give XNOR(a,b); four more give XNOR(that, c) = a^b^c.
    assign n_ab = ~(a | b);
    assign n_a  = ~(a | n_ab);
    assign n_b  = ~(b | n_ab);
    assign x_ab = ~(n_a | n_b);
    assign n_xc = ~(x_ab | c);
    assign n_x  = ~(x_ab | n_xc);
    assign n_c  = ~(c | n_xc);
    assign s    = ~(n_x | n_c);
    // (a|b) & (xnor(a,b)|c) reduces to the majority function.
    assign co   = ~(n_ab | n_xc);
endmodule

module serial_adder_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_adder_arbiter_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             busy_q;
    logic             done_q;
    logic             grant_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             pick_valid;
    logic             pick_id;
    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] sum_next;

    // On a tie the requester not served last wins; otherwise the lone requester.
    always_comb begin
        pick_valid = bus.req0 | bus.req1;
        pick_id    = (bus.req0 && bus.req1) ? ~last : bus.req1;
    end

    full_adder_nor u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .c  (carry),
        .s  (fa_s),
        .co (fa_c)
    );

    // Only the upper WIDTH-1 result bits need storing; the newest bit enters at the MSB.
    assign sum_next = {fa_s, sum_sr};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            last    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            grant_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (pick_valid) begin
                        grant_q <= pick_id;
                        last    <= pick_id;
                        a_sr    <= pick_id ? bus.a1 : bus.a0;
                        b_sr    <= pick_id ? bus.b1 : bus.b0;
                        carry   <= pick_id ? bus.cin1 : bus.cin0;
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum_sr <= sum_next[WIDTH-1:1];
                    carry  <= fa_c;
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum_q  <= sum_next;
                        cout_q <= fa_c;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.grant = grant_q;
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
endmodule
